logical_arbiter: RTL
====================

// Module: logical_arbiter
//
// PURPOSE
//   Shares one bitwise logical unit (AND/OR/XOR/NOR) between two requesters.
//   Each requester uses a valid/ready handshake. Arbitration is round-robin.
//   The result is registered and returned on a single output channel, tagged
//   with the id of the winning requester. The block sits between the
//   execute-stage issue logic and the logical datapath, so two independent
//   issue slots can use one unit without contention.
//
// PARAMETERS
//   N    32   operand / result width in bits
//
// PORTS
//   clk         in   1   rising-edge clock
//   reset_n     in   1   asynchronous active-low reset
//   in0_valid   in   1   requester 0 presents an operation
//   in0_ready   out  1   requester 0 operation accepted this cycle
//   in0_a       in   N   requester 0 operand A
//   in0_b       in   N   requester 0 operand B
//   in0_op      in   2   requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
//   in1_valid   in   1   requester 1 presents an operation
//   in1_ready   out  1   requester 1 operation accepted this cycle
//   in1_a       in   N   requester 1 operand A
//   in1_b       in   N   requester 1 operand B
//   in1_op      in   2   requester 1 opcode (same encoding as in0_op)
//   out_valid   out  1   out_r and out_id hold a valid result
//   out_ready   in   1   consumer accepts the result this cycle
//   out_r       out  N   registered result
//   out_id      out  1   id of the requester that produced out_r
//
// BEHAVIOUR
//   - Reset (reset_n=0, async): out_valid=0, out_r=0, out_id=0, rr_ptr=0.
//     in0_ready and in1_ready are forced to 0 while reset_n is low.
//   - Output slot is free when (!out_valid || out_ready).
//   - Grant is combinational:
//     - Slot free and only inK_valid high: grant K.
//     - Slot free and both valid: grant rr_ptr.
//     - Slot not free: no grant.
//   - inK_ready = grant K. A transfer is valid & ready in the same cycle.
//   - Latency is 1 cycle. An op accepted at edge T shows on out_* after T:
//     out_valid=1, out_r=f(a,b,op) of the winner, out_id=winner.
//   - Ops: 00 A&B, 01 A|B, 10 A^B, 11 ~(A|B). All are bitwise and width N.
//     There is no carry or overflow.
//   - Throughput: with out_ready=1 and a request pending, one result is
//     produced every cycle.
//   - If out_valid&&out_ready and a grant occur in the same cycle, the
//     output register loads the new result and out_valid stays 1.
//   - If out_valid&&out_ready with no grant, out_valid goes to 0 next cycle.
//     out_r holds its last value (don't-care).
//   - Backpressure: while out_valid=1 and out_ready=0, out_r and out_id are
//     held stable and both readies are 0. No result is dropped.
//   - rr_ptr updates only on a grant. After granting K, rr_ptr = !K.
//     When no grant occurs, rr_ptr keeps its value.
//   - A requester must hold valid/a/b/op stable until ready. The block does
//     not latch operands before the grant.
//   - Reset asserted mid-operation: the in-flight result is discarded,
//     out_valid falls asynchronously and rr_ptr returns to 0.
//
// TESTING
//   1. Hold reset_n=0 with both valids high -> out_valid=0, out_r=0,
//      in0_ready=in1_ready=0. Release reset -> in0 is granted first.
//   2. in0 only, A=F0F0F0F0, B=FF00FF00, op=00 -> next cycle out_valid=1,
//      out_r=F000F000, out_id=0.
//   3. Both valid continuously, out_ready=1 -> grants alternate 0,1,0,1.
//      One result per cycle; out_id sequence is 0,1,0,1.
//   4. in1, A=0000000F, B=000000F0, op=11 -> out_r=FFFFFF00, out_id=1.
//      Same operands with op=10 -> 000000FF.
//   5. out_ready=0 for 3 cycles with both valid -> out_r/out_id stable and
//      readies 0. Raise out_ready -> new grant that same cycle, with no
//      result lost or duplicated.
//   6. Drop reset_n while out_valid=1 -> out_valid=0 immediately. After
//      release, with both valid, in0 is granted (rr_ptr=0).

Source files
------------

// File: rtl/logical_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (AND/OR/XOR/NOR)
// between two valid/ready requesters; results return tagged with the winner id.
module logical_arbiter #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [N-1:0] in0_a,
    input  logic [N-1:0] in0_b,
    input  logic [1:0]   in0_op,
    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [N-1:0] in1_a,
    input  logic [N-1:0] in1_b,
    input  logic [1:0]   in1_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic         out_id
);

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_r_q, out_r_d;
    logic         out_id_q, out_id_d;
    logic         rr_ptr_q, rr_ptr_d;

    logic         slot_free;
    logic         gnt0, gnt1;
    logic [N-1:0] sel_a, sel_b;
    logic [1:0]   sel_op;
    logic [N-1:0] result;

    // Readies are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        gnt0      = reset_n && slot_free && in0_valid && (!in1_valid || !rr_ptr_q);
        gnt1      = reset_n && slot_free && in1_valid && (!in0_valid || rr_ptr_q);
    end

    always_comb begin
        sel_a  = gnt1 ? in1_a  : in0_a;
        sel_b  = gnt1 ? in1_b  : in0_b;
        sel_op = gnt1 ? in1_op : in0_op;
        result = '0;
        unique case (sel_op)
            2'b00: result = sel_a & sel_b;
            2'b01: result = sel_a | sel_b;
            2'b10: result = sel_a ^ sel_b;
            2'b11: result = ~(sel_a | sel_b);
            default: result = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt0 || gnt1) begin
            out_valid_d = 1'b1;
            out_r_d     = result;
            out_id_d    = gnt1;
            // Point at the requester that lost this round.
            rr_ptr_d    = gnt0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_id_q    <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign in0_ready = gnt0;
    assign in1_ready = gnt1;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_id    = out_id_q;

endmodule
